bec_op_sequencer: RTL and testbench

//  Drives one BEC scalar-multiplication run end to end.
//  - Waits for the core to report ready, pushes the six curve operands, arms the core.
//  - Streams key bits on request, captures the W/Z results and guards the run with a timeout.
//  - Sits between the LA/wishbone-facing operand registers and the BEC core; replaces ad-hoc counter sequencing.

---
 rtl/bec_pkg.sv | 32 +++
 rtl/bec_key_shifter.sv | 47 ++++
 rtl/bec_op_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_bec_op_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bec_pkg.sv
// Shared definitions for the BEC operand sequencer.
//   BEC_WIDTH   : GF(2^163) element width used for operands, key and results
//   BEC_NUM_OPS : operands pushed to the core per run
//   BEC_READY   : core status code meaning "ready to accept operands"
//   state_t     : sequencer FSM states
//   op_sel_t    : operand indices as seen on op_idx / bec_load_status
package bec_pkg;

  localparam int BEC_WIDTH   = 163;
  localparam int BEC_NUM_OPS = 6;

  localparam logic [3:0] BEC_READY = 4'h8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_LOAD,
    ST_ARM,
    ST_RUN,
    ST_CAP_Z
  } state_t;

  typedef enum logic [2:0] {
    OP_W1     = 3'd0,
    OP_Z1     = 3'd1,
    OP_W2     = 3'd2,
    OP_Z2     = 3'd3,
    OP_INV_W0 = 3'd4,
    OP_D      = 3'd5
  } op_sel_t;

endpackage

// File: rtl/bec_key_shifter.sv
// Scalar key register for the BEC run.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   load     : capture key into the shift register
//   key      : scalar key value
//   rotate   : rotate right by one (bit 0 wraps to bit WIDTH-1)
//   run      : sequencer will be in RUN next cycle; ki is forced to 0 otherwise
//   ki       : registered current key bit
module bec_key_shifter
  import bec_pkg::*;
#(
  parameter int WIDTH = BEC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] key,
  input  logic             rotate,
  input  logic             run,
  output logic             ki
);

  logic [WIDTH-1:0] key_sr;
  logic [WIDTH-1:0] sr_next;

  always_comb begin
    sr_next = key_sr;
    if (load) begin
      sr_next = key;
    end else if (rotate) begin
      sr_next = {key_sr[0], key_sr[WIDTH-1:1]};
    end
  end

  // ki is taken from the post-rotate value so a request is reflected
  // exactly one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_sr <= '0;
      ki     <= 1'b0;
    end else begin
      key_sr <= sr_next;
      ki     <= run & sr_next[0];
    end
  end

endmodule

// File: rtl/bec_op_sequencer.sv
// Sequences one BEC scalar-multiplication run: waits for core ready, pushes
// the curve operands, arms the core, streams key bits, captures W and Z and
// guards RUN with a watchdog.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   start, abort       : run request (IDLE only) / cancel (any state, wins)
//   key                : scalar key, sampled on accepted start
//   op_idx, op_data    : operand select to register file and returned operand
//   bec_load, bec_load_status, bec_data : operand beat to the core
//   bec_enable, bec_ki : core run enable and current key bit
//   bec_next_key, bec_status, bec_done, bec_result : core handshake
//   busy, done, timeout_err, w_out, z_out : run status and captured results
module bec_op_sequencer
  import bec_pkg::*;
#(
  parameter int WIDTH     = BEC_WIDTH,
  parameter int NUM_OPS   = BEC_NUM_OPS,
  parameter int TIMEOUT_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] key,
  output logic [2:0]       op_idx,
  input  logic [WIDTH-1:0] op_data,
  output logic             bec_load,
  output logic [2:0]       bec_load_status,
  output logic [WIDTH-1:0] bec_data,
  output logic             bec_enable,
  output logic             bec_ki,
  input  logic             bec_next_key,
  input  logic [3:0]       bec_status,
  input  logic             bec_done,
  input  logic [WIDTH-1:0] bec_result,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [WIDTH-1:0] w_out,
  output logic [WIDTH-1:0] z_out
);

  localparam int CNT_W = $clog2(NUM_OPS + 1);
  // Expiry is detected one count early so the counter lands on all-ones
  // on the edge that leaves RUN: exactly 2^TIMEOUT_W-1 RUN cycles.
  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'((64'd1 << TIMEOUT_W) - 64'd2);

  state_t               state, state_next;
  logic [CNT_W-1:0]     load_cnt, load_cnt_next;
  logic [TIMEOUT_W-1:0] wd_cnt, wd_cnt_next;
  logic [2:0]           op_idx_next;
  logic                 bec_load_next;
  logic [2:0]           load_status_next;
  logic [WIDTH-1:0]     bec_data_next;
  logic                 bec_enable_next;
  logic                 done_next;
  logic                 timeout_err_next;
  logic [WIDTH-1:0]     w_out_next, z_out_next;
  logic                 key_load, key_rotate, key_run;

  // LOAD issues one beat per cycle while load_cnt < NUM_OPS, then spends
  // one more cycle with the last beat on the bus before moving to ARM, so
  // ARM is seen by the core as a cycle with bec_load low.
  always_comb begin
    state_next       = state;
    load_cnt_next    = load_cnt;
    wd_cnt_next      = wd_cnt;
    op_idx_next      = op_idx;
    bec_load_next    = 1'b0;
    load_status_next = bec_load_status;
    bec_data_next    = bec_data;
    bec_enable_next  = bec_enable;
    done_next        = 1'b0;
    timeout_err_next = timeout_err;
    w_out_next       = w_out;
    z_out_next       = z_out;
    key_load         = 1'b0;
    key_rotate       = 1'b0;

    if (abort) begin
      state_next      = ST_IDLE;
      bec_enable_next = 1'b0;
      op_idx_next     = 3'(OP_W1);
      load_cnt_next   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            key_load         = 1'b1;
            timeout_err_next = 1'b0;
            state_next       = ST_WAIT_RDY;
          end
        end
        ST_WAIT_RDY: begin
          if (bec_status == BEC_READY) begin
            op_idx_next   = 3'(OP_W1);
            load_cnt_next = '0;
            state_next    = ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (load_cnt != CNT_W'(NUM_OPS)) begin
            bec_load_next    = 1'b1;
            load_status_next = op_idx;
            bec_data_next    = op_data;
            load_cnt_next    = load_cnt + CNT_W'(1);
            op_idx_next      = (op_idx == 3'(NUM_OPS - 1)) ? 3'(OP_W1) : op_idx + 3'd1;
          end else begin
            state_next = ST_ARM;
          end
        end
        ST_ARM: begin
          bec_enable_next = 1'b1;
          wd_cnt_next     = '0;
          state_next      = ST_RUN;
        end
        ST_RUN: begin
          key_rotate  = bec_next_key;
          wd_cnt_next = wd_cnt + TIMEOUT_W'(1);
          if (bec_done) begin
            w_out_next      = bec_result;
            bec_enable_next = 1'b0;
            state_next      = ST_CAP_Z;
          end else if (wd_cnt == WD_LAST) begin
            timeout_err_next = 1'b1;
            bec_enable_next  = 1'b0;
            state_next       = ST_IDLE;
          end
        end
        ST_CAP_Z: begin
          z_out_next = bec_result;
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
        default: begin
          state_next      = ST_IDLE;
          bec_enable_next = 1'b0;
        end
      endcase
    end
  end

  assign key_run = (state_next == ST_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      load_cnt        <= '0;
      wd_cnt          <= '0;
      op_idx          <= '0;
      bec_load        <= 1'b0;
      bec_load_status <= '0;
      bec_data        <= '0;
      bec_enable      <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      timeout_err     <= 1'b0;
      w_out           <= '0;
      z_out           <= '0;
    end else begin
      state           <= state_next;
      load_cnt        <= load_cnt_next;
      wd_cnt          <= wd_cnt_next;
      op_idx          <= op_idx_next;
      bec_load        <= bec_load_next;
      bec_load_status <= load_status_next;
      bec_data        <= bec_data_next;
      bec_enable      <= bec_enable_next;
      busy            <= (state_next != ST_IDLE);
      done            <= done_next;
      timeout_err     <= timeout_err_next;
      w_out           <= w_out_next;
      z_out           <= z_out_next;
    end
  end

  bec_key_shifter #(
    .WIDTH (WIDTH)
  ) u_key_shifter (
    .clk    (clk),
    .rst    (rst),
    .load   (key_load),
    .key    (key),
    .rotate (key_rotate),
    .run    (key_run),
    .ki     (bec_ki)
  );

endmodule

// File: tb/tb_bec_op_sequencer.sv
// Self-checking bench for bec_op_sequencer with randomized operands, keys,
// key-request patterns and results, checked against a spec-level model.
module tb_bec_op_sequencer;

  localparam int W  = 163;
  localparam int TW = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic [W-1:0]  key;
  logic [2:0]    op_idx;
  logic [W-1:0]  op_data;
  logic          bec_load;
  logic [2:0]    bec_load_status;
  logic [W-1:0]  bec_data;
  logic          bec_enable;
  logic          bec_ki;
  logic          bec_next_key;
  logic [3:0]    bec_status;
  logic          bec_done;
  logic [W-1:0]  bec_result;
  logic          busy;
  logic          done;
  logic          timeout_err;
  logic [W-1:0]  w_out;
  logic [W-1:0]  z_out;

  logic [W-1:0]  ops [0:7];
  logic [W-1:0]  lastW, lastZ;
  int            assertCount = 0;
  int            failCount   = 0;

  assign op_data = ops[op_idx];

  bec_op_sequencer #(
    .WIDTH     (W),
    .NUM_OPS   (6),
    .TIMEOUT_W (TW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .key             (key),
    .op_idx          (op_idx),
    .op_data         (op_data),
    .bec_load        (bec_load),
    .bec_load_status (bec_load_status),
    .bec_data        (bec_data),
    .bec_enable      (bec_enable),
    .bec_ki          (bec_ki),
    .bec_next_key    (bec_next_key),
    .bec_status      (bec_status),
    .bec_done        (bec_done),
    .bec_result      (bec_result),
    .busy            (busy),
    .done            (done),
    .timeout_err     (timeout_err),
    .w_out           (w_out),
    .z_out           (z_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got still running, expected finished");
    $fatal(1, "[TB] simulation bound exceeded");
  end

  function automatic logic [W-1:0] rand163();
    return W'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] actual, input logic [W-1:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic nk, input logic dn,
                               input logic [3:0] st, input logic [W-1:0] res);
    start        = s;
    abort        = a;
    bec_next_key = nk;
    bec_done     = dn;
    bec_status   = st;
    bec_result   = res;
  endtask

  task automatic checkAllZero();
    checkOutput("rst_op_idx", W'(op_idx), W'(0));
    checkOutput("rst_bec_load", W'(bec_load), W'(0));
    checkOutput("rst_load_status", W'(bec_load_status), W'(0));
    checkOutput("rst_bec_data", bec_data, W'(0));
    checkOutput("rst_bec_enable", W'(bec_enable), W'(0));
    checkOutput("rst_bec_ki", W'(bec_ki), W'(0));
    checkOutput("rst_busy", W'(busy), W'(0));
    checkOutput("rst_done", W'(done), W'(0));
    checkOutput("rst_timeout_err", W'(timeout_err), W'(0));
    checkOutput("rst_w_out", w_out, W'(0));
    checkOutput("rst_z_out", z_out, W'(0));
  endtask

  // Starts a run, holds core status not-ready for 'hold' cycles, then checks
  // the six operand beats and the two-cycle gap to bec_enable. Returns with
  // the first RUN cycle being sampled.
  task automatic startAndLoad(input logic [W-1:0] k, input int hold);
    bit sawLoad;
    int beatN, lastBeat, cyc;
    for (int i = 0; i < 8; i++) ops[i] = rand163();
    checkOutput("idle_busy", W'(busy), W'(0));
    key = k;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, rand163());
    tick();
    key = rand163();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, rand163());
    checkOutput("start_busy", W'(busy), W'(1));
    checkOutput("start_clears_terr", W'(timeout_err), W'(0));
    sawLoad = 1'b0;
    for (int h = 0; h < hold; h++) begin
      tick();
      if (bec_load) sawLoad = 1'b1;
    end
    if (hold > 0) checkOutput("wait_no_load", W'(sawLoad), W'(0));
    bec_status = 4'h8;
    tick();
    checkOutput("load_entry", W'(bec_load), W'(0));
    bec_status = 4'($urandom_range(0, 7));
    tick();
    checkOutput("first_beat", W'(bec_load), W'(1));
    beatN = 0;
    lastBeat = -10;
    cyc = 0;
    while (cyc < 20 && !bec_enable) begin
      if (bec_load) begin
        checkOutput("beat_status", W'(bec_load_status), W'(beatN));
        if (beatN < 8) checkOutput("beat_data", bec_data, ops[beatN]);
        lastBeat = cyc;
        beatN++;
      end
      tick();
      cyc++;
    end
    checkOutput("arm_seen", W'(bec_enable), W'(1));
    checkOutput("beat_count", W'(beatN), W'(6));
    checkOutput("last_beat_cyc", W'(lastBeat), W'(5));
    checkOutput("enable_gap", W'(cyc - lastBeat), W'(2));
    checkOutput("run_load_low", W'(bec_load), W'(0));
  endtask

  // Runs RUN for nCycles with key requests from mask, then returns W/Z.
  task automatic finishRun(input logic [W-1:0] k, input logic [15:0] mask, input int nCycles,
                           input logic [W-1:0] wRes, input logic [W-1:0] zRes);
    int p;
    p = 0;
    for (int c = 0; c < nCycles; c++) begin
      checkOutput("run_enable", W'(bec_enable), W'(1));
      checkOutput("run_ki", W'(bec_ki), W'(k[p % W]));
      bec_next_key = mask[c];
      tick();
      if (mask[c]) p++;
    end
    checkOutput("run_enable", W'(bec_enable), W'(1));
    checkOutput("run_ki", W'(bec_ki), W'(k[p % W]));
    applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 4'h8, wRes);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h8, zRes);
    checkOutput("capz_w_out", w_out, wRes);
    checkOutput("capz_enable", W'(bec_enable), W'(0));
    checkOutput("capz_ki", W'(bec_ki), W'(0));
    checkOutput("capz_no_done", W'(done), W'(0));
    tick();
    bec_result = rand163();
    checkOutput("done_pulse", W'(done), W'(1));
    checkOutput("done_w_out", w_out, wRes);
    checkOutput("done_z_out", z_out, zRes);
    checkOutput("done_busy", W'(busy), W'(0));
    checkOutput("done_terr", W'(timeout_err), W'(0));
    lastW = wRes;
    lastZ = zRes;
    tick();
    checkOutput("done_one_cycle", W'(done), W'(0));
    checkOutput("hold_z_out", z_out, zRes);
  endtask

  initial begin
    bit sawDone, sawLoad;
    int enCount;
    logic [W-1:0] k;

    rst = 1'b1;
    key = '0;
    for (int i = 0; i < 8; i++) ops[i] = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, '0);
    lastW = '0;
    lastZ = '0;
    repeat (2) tick();
    rst = 1'b0;
    checkAllZero();
    tick();

    $display("[TB] directed run: key=5, three key requests");
    startAndLoad(W'(5), 0);
    finishRun(W'(5), 16'h0007, 3, W'(8'hA5), W'(8'h3C));

    $display("[TB] ready held off for 10 cycles");
    k = rand163();
    startAndLoad(k, 10);
    finishRun(k, 16'($urandom()), $urandom_range(0, 10), rand163(), rand163());

    $display("[TB] randomized runs");
    for (int r = 0; r < 6; r++) begin
      k = rand163();
      startAndLoad(k, $urandom_range(0, 3));
      finishRun(k, 16'($urandom()), $urandom_range(0, 10), rand163(), rand163());
    end

    $display("[TB] done on the last watchdog cycle");
    k = rand163();
    startAndLoad(k, 0);
    finishRun(k, 16'($urandom()), (1 << TW) - 2, rand163(), rand163());

    $display("[TB] reset during RUN");
    startAndLoad(rand163(), 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lastW = '0;
    lastZ = '0;
    checkAllZero();
    tick();
    checkOutput("post_rst_busy", W'(busy), W'(0));

    $display("[TB] watchdog expiry");
    k = rand163();
    startAndLoad(k, 0);
    finishRun(k, 16'h0, 0, rand163(), rand163());
    startAndLoad(k, 0);
    enCount = 0;
    sawDone = 1'b0;
    for (int c = 0; c < 40 && bec_enable; c++) begin
      enCount++;
      if (done) sawDone = 1'b1;
      tick();
    end
    checkOutput("timeout_run_cycles", W'(enCount), W'((1 << TW) - 1));
    checkOutput("timeout_err_set", W'(timeout_err), W'(1));
    checkOutput("timeout_enable", W'(bec_enable), W'(0));
    checkOutput("timeout_busy", W'(busy), W'(0));
    checkOutput("timeout_no_done", W'(sawDone | done), W'(0));
    checkOutput("timeout_w_out", w_out, lastW);
    tick();
    checkOutput("timeout_sticky", W'(timeout_err), W'(1));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, '0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, '0);
    checkOutput("restart_clears_terr", W'(timeout_err), W'(0));
    checkOutput("restart_busy", W'(busy), W'(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_wait_busy", W'(busy), W'(0));

    $display("[TB] abort on third load beat");
    for (int i = 0; i < 8; i++) ops[i] = rand163();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h8, '0);
    tick();
    start = 1'b0;
    repeat (4) tick();
    checkOutput("third_beat_load", W'(bec_load), W'(1));
    checkOutput("third_beat_status", W'(bec_load_status), W'(2));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_busy", W'(busy), W'(0));
    checkOutput("abort_load", W'(bec_load), W'(0));
    checkOutput("abort_enable", W'(bec_enable), W'(0));
    sawLoad = 1'b0;
    sawDone = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bec_load | bec_enable) sawLoad = 1'b1;
      if (done) sawDone = 1'b1;
    end
    checkOutput("abort_stays_idle", W'(sawLoad | busy), W'(0));
    checkOutput("abort_no_done", W'(sawDone), W'(0));
    checkOutput("abort_w_out", w_out, lastW);
    checkOutput("abort_z_out", z_out, lastZ);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'h8, '0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h8, '0);
    checkOutput("abort_start_busy", W'(busy), W'(0));
    sawLoad = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bec_load | busy) sawLoad = 1'b1;
    end
    checkOutput("abort_start_idle", W'(sawLoad), W'(0));

    $display("[TB] run after abort");
    k = rand163();
    startAndLoad(k, 1);
    finishRun(k, 16'($urandom()), $urandom_range(0, 10), rand163(), rand163());

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
